spi_master_mcs: RTL and testbench
=================================

SPI_MASTER_MCS -- requirements
Module: spi_master_mcs

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per word, legal 4..32.
REQ-002 Parameter NUM_SS, default 4: number of slave selects, legal 1..8; SS_W = max(1, clog2(NUM_SS)).
REQ-003 Parameter FIFO_DEPTH, default 4: entries in each of the TX and RX FIFOs, power of two, 2..16.
REQ-004 clk  in  1: single clock, all logic on rising edge.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 cfg_cpol, cfg_cpha  in  1 each: SPI mode bits.
REQ-007 cfg_lsb_first  in  1: 1 = LSB shifted first, 0 = MSB first.
REQ-008 cfg_clk_div  in  8: SCLK half-period = cfg_clk_div+1 clk cycles.
REQ-009 cfg_ss_sel  in  SS_W: index of the slave to select; values >= NUM_SS select none (ss_n stays all ones, transfer still runs).
REQ-010 tx_data  in  DATA_WIDTH; tx_last  in  1; tx_valid  in  1; tx_ready  out  1: TX FIFO push port; tx_last=1 ends the burst after this word.
REQ-011 rx_data  out  DATA_WIDTH; rx_valid  out  1; rx_ready  in  1: RX FIFO pop port.
REQ-012 sclk  out  1; mosi  out  1; miso  in  1; ss_n  out  NUM_SS.
REQ-013 busy  out  1: high in every state except IDLE.

Function
REQ-014 Push occurs when tx_valid & tx_ready; tx_ready = TX FIFO not full; pop occurs when rx_valid & rx_ready; rx_valid = RX FIFO not empty; rx_data shows FIFO head combinationally.
REQ-015 Simultaneous push and pop on a full RX or TX FIFO shall be handled as pop-then-push only on the side doing both (count unchanged).
REQ-016 FSM states: IDLE, ASSERT, SHIFT, HOLD, RELEASE.
REQ-017 IDLE: sclk = cfg_cpol, ss_n all ones; on TX FIFO non-empty latch cpol, cpha, lsb_first, clk_div, ss_sel, go to ASSERT; config changes mid-burst shall have no effect.
REQ-018 ASSERT: drive selected ss_n low, pop TX word into shift register, drive first data bit on mosi, wait one half-period, go to SHIFT.
REQ-019 SHIFT: generate 2*DATA_WIDTH SCLK edges, one per half-period; CPHA=0 samples miso on odd-numbered edges (1st, 3rd, ...) and shifts mosi on even edges; CPHA=1 shifts on odd edges and samples on even edges.
REQ-020 After the last edge, the received word shall be pushed to the RX FIFO and the state shall go to HOLD; sclk then rests at latched cpol.
REQ-021 HOLD lasts one half-period; then if latched word had tx_last=1 go to RELEASE; else if TX FIFO non-empty and RX FIFO not full pop next word, load first bit, go to SHIFT with ss_n still low; else stay in HOLD.
REQ-022 RX FIFO full shall never drop data: a new word shall not start while RX FIFO is full.
REQ-023 RELEASE: ss_n all ones for one half-period, then IDLE.
REQ-024 Half-period counter counts 0..clk_div and wraps; cfg_clk_div=0 gives sclk = clk/2.
REQ-025 mosi shall hold its last value outside SHIFT/HOLD; miso is sampled unsynchronised.

Reset
REQ-026 During rst_n low: state IDLE, sclk=0, mosi=0, ss_n all ones, busy=0, both FIFOs empty (tx_ready=1, rx_valid=0), counters zero.
REQ-027 Reset asserted mid-transfer shall abort immediately with the values of REQ-026; no partial word shall reach the RX FIFO.

Structure
REQ-028 Package spi_pkg shall hold the FSM state enum and the SS_W width function.
REQ-029 One sub-module spi_fifo (parametrised width/depth synchronous FIFO) shall be instantiated twice, for TX and RX.

Verification
REQ-030 Mode sweep, DATA_WIDTH=8, miso looped to mosi, clk_div=1: send 0xA5 tx_last=1 in modes 0-3 -> rx_data=0xA5 each mode, 32 clk-cycle SHIFT per word.
REQ-031 Burst: push 0x11,0x22,0x33 (last on 0x33), ss_sel=2 -> ss_n[2] low continuously across 3 words, others high, rx returns 0x11,0x22,0x33.
REQ-032 LSB-first: 0x01, cfg_lsb_first=1 -> first mosi bit 1; miso model returning 0x80 MSB-first order reads 0x01.
REQ-033 Backpressure: rx_ready=0, push 6 words depth 4 -> 4 words received, busy stays high in HOLD, ss_n low; releasing rx_ready completes all 6 in order.
REQ-034 Reset mid-word after 5 edges -> next cycle ss_n all ones, sclk=0, rx_valid=0.
REQ-035 ss_sel=7 with NUM_SS=4 -> transfer timing normal, ss_n stays 4'b1111.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and slave-select width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SHIFT,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  function automatic int unsigned ss_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with combinational head; a push on a full FIFO is accepted
// only when a pop happens in the same cycle (count unchanged).
module spi_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with TX/RX FIFOs, multiple slave selects and burst transfers.
// Configuration is latched at burst start; SCLK half-period is clk_div+1 cycles.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned NUM_SS     = 4,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SS_W       = ss_width(NUM_SS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [7:0]            cfg_clk_div,
  input  logic [SS_W-1:0]       cfg_ss_sel,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n,
  output logic                  busy
);
  localparam int unsigned EW = $clog2(2 * DATA_WIDTH);

  state_t                r_state, w_state_next;
  logic                  r_cpol, r_cpha, r_lsb, r_last, r_sclk, r_hold_done;
  logic [7:0]            r_clk_div, r_div_cnt;
  logic [SS_W-1:0]       r_ss_sel;
  logic [DATA_WIDTH-1:0] r_tx_sh, r_rx_sh, w_rx_next;
  logic [EW-1:0]         r_edge_cnt;
  logic [DATA_WIDTH:0]   w_tx_head;
  logic                  w_tick, w_last_edge, w_sample, w_advance;
  logic                  w_tx_pop, w_rx_push, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;

  spi_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(tx_valid && !w_tx_full), .i_data({tx_last, tx_data}),
    .i_pop(w_tx_pop), .o_data(w_tx_head),
    .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  spi_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_rx_push), .i_data(w_rx_next),
    .i_pop(rx_ready && !w_rx_empty), .o_data(rx_data),
    .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign tx_ready    = !w_tx_full;
  assign rx_valid    = !w_rx_empty;
  assign busy        = (r_state != ST_IDLE);
  assign sclk        = r_sclk;
  assign mosi        = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_WIDTH-1];
  assign w_tick      = (r_div_cnt == r_clk_div);
  assign w_last_edge = (r_edge_cnt == EW'(2 * DATA_WIDTH - 1));
  // Even edge index = odd-numbered edge; CPHA selects which parity samples.
  // The first bit is already on mosi before edge 1, so CPHA=1 skips that advance
  // and CPHA=0 skips the advance on the final edge to keep mosi stable.
  assign w_sample    = (r_edge_cnt[0] == r_cpha);
  assign w_advance   = !w_sample && !(r_cpha ? (r_edge_cnt == '0) : w_last_edge);

  always_comb begin
    w_rx_next = r_rx_sh;
    if (w_sample)
      w_rx_next = r_lsb ? {miso, r_rx_sh[DATA_WIDTH-1:1]} : {r_rx_sh[DATA_WIDTH-2:0], miso};
  end

  always_comb begin
    ss_n = '1;
    if (r_state == ST_ASSERT || r_state == ST_SHIFT || r_state == ST_HOLD) begin
      for (int unsigned i = 0; i < NUM_SS; i++)
        if (r_ss_sel == SS_W'(i)) ss_n[i] = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_rx_push    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_tx_empty && !w_rx_full) begin
          w_tx_pop     = 1'b1;
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT:  if (w_tick) w_state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_tick && w_last_edge) begin
          w_rx_push    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tick || r_hold_done) begin
          if (r_last) begin
            w_state_next = ST_RELEASE;
          end else if (!w_tx_empty && !w_rx_full) begin
            w_tx_pop     = 1'b1;
            w_state_next = ST_SHIFT;
          end
        end
      end
      ST_RELEASE: if (w_tick) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
      r_last      <= 1'b0;
      r_sclk      <= 1'b0;
      r_hold_done <= 1'b0;
      r_clk_div   <= '0;
      r_div_cnt   <= '0;
      r_ss_sel    <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_edge_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_sclk <= cfg_cpol;
        if (w_tx_pop) begin
          r_cpol    <= cfg_cpol;
          r_cpha    <= cfg_cpha;
          r_lsb     <= cfg_lsb_first;
          r_clk_div <= cfg_clk_div;
          r_ss_sel  <= cfg_ss_sel;
        end
      end else if (r_state == ST_SHIFT && w_tick) begin
        r_sclk     <= w_last_edge ? r_cpol : !r_sclk;
        r_edge_cnt <= r_edge_cnt + 1'b1;
        r_rx_sh    <= w_rx_next;
        if (w_advance) r_tx_sh <= r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
      end
      if (w_tx_pop) begin
        r_tx_sh    <= w_tx_head[DATA_WIDTH-1:0];
        r_last     <= w_tx_head[DATA_WIDTH];
        r_rx_sh    <= '0;
        r_edge_cnt <= '0;
      end
      r_hold_done <= (r_state == ST_HOLD) && (w_state_next == ST_HOLD) && (r_hold_done || w_tick);
      if (r_state == ST_IDLE || w_state_next != r_state || w_tick) r_div_cnt <= '0;
      else                                                          r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed self-checking bench for spi_master_mcs (8-bit words, 5 slave selects, depth 4).
module tb_spi_master_mcs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [7:0] cfg_clk_div = 8'd1;
  logic [2:0] cfg_ss_sel = 3'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
  logic       tx_ready, rx_valid, sclk, mosi, miso, busy;
  logic [7:0] rx_data;
  logic [4:0] ss_n;

  int total = 0, bad = 0;
  int busy_cyc = 0, low_cyc = 0, edges = 0, ss_bad = 0, ss_fall = 0, falls = 0, fall_base = 0;
  logic       prev_sclk = 1'b0;
  logic [4:0] prev_ss = 5'h1F, exp_ss = 5'h1E;
  logic       use_model = 1'b0, model_bit;
  logic [7:0] pat = 8'h80;
  int         k;

  spi_master_mcs #(.DATA_WIDTH(8), .NUM_SS(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_clk_div(cfg_clk_div), .cfg_ss_sel(cfg_ss_sel),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave model for mode 0: presents pat MSB first, advancing on each falling sclk.
  always_comb begin
    k = falls - fall_base;
    model_bit = 1'b0;
    if (k >= 0 && k < 8) model_bit = pat[3'(7 - k)];
  end
  assign miso = use_model ? model_bit : mosi;

  always @(negedge sclk) if (use_model) falls++;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_cyc++;
      if (sclk !== prev_sclk) edges++;
    end
    if (ss_n !== 5'h1F) begin
      low_cyc++;
      if (ss_n !== exp_ss) ss_bad++;
    end
    if (prev_ss === 5'h1F && ss_n !== 5'h1F) ss_fall++;
    prev_sclk = sclk;
    prev_ss   = ss_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (tx_ready !== 1'b1) check("push_timeout", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] e);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check(tag, 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (busy !== 1'b1) check("start_timeout", 32'(busy), 32'd1);
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) check("done_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int e0, l0, b0, f0, s0, n;
    logic [1:0] mm;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ss_n", 32'(ss_n), 32'h1F);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode sweep, loopback, 0xA5
    exp_ss = 5'h1E;
    for (int m = 0; m < 4; m++) begin
      mm = 2'(m);
      cfg_cpol = mm[1]; cfg_cpha = mm[0];
      repeat (3) @(negedge clk);
      e0 = edges; l0 = low_cyc;
      push(8'hA5, 1'b1);
      wait_done();
      check($sformatf("mode%0d_edges", m), 32'(edges - e0), 32'd16);
      check($sformatf("mode%0d_ss_low", m), 32'(low_cyc - l0), 32'd36);
      pop_check($sformatf("mode%0d_rx", m), 8'hA5);
    end
    cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    repeat (3) @(negedge clk);

    // Burst on slave 2; config changed mid-burst must be ignored
    cfg_ss_sel = 3'd2; exp_ss = 5'h1B;
    l0 = low_cyc; f0 = ss_fall; s0 = ss_bad;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    cfg_ss_sel = 3'd0;
    push(8'h33, 1'b1);
    wait_done();
    check("burst_ss_low", 32'(low_cyc - l0), 32'd104);
    check("burst_ss_falls", 32'(ss_fall - f0), 32'd1);
    check("burst_ss_pattern", 32'(ss_bad - s0), 32'd0);
    pop_check("burst_rx0", 8'h11);
    pop_check("burst_rx1", 8'h22);
    pop_check("burst_rx2", 8'h33);

    // LSB first with slave model returning 0x80 MSB-first
    cfg_ss_sel = 3'd0; exp_ss = 5'h1E; cfg_lsb_first = 1'b1;
    fall_base = falls; use_model = 1'b1;
    push(8'h01, 1'b1);
    n = 0;
    while (ss_n[0] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("lsb_first_mosi", 32'(mosi), 32'd1);
    wait_done();
    pop_check("lsb_rx", 8'h01);
    use_model = 1'b0; cfg_lsb_first = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: RX full stalls in HOLD with slave still selected
    cfg_ss_sel = 3'd1; exp_ss = 5'h1D;
    e0 = edges; f0 = ss_fall; s0 = ss_bad;
    for (int w = 0; w < 6; w++) push(8'(8'h31 + w), (w == 5));
    repeat (400) @(negedge clk);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_ss_n", 32'(ss_n), 32'h1D);
    check("bp_edges_4words", 32'(edges - e0), 32'd64);
    check("bp_tx_ready", 32'(tx_ready), 32'd1);
    for (int w = 0; w < 6; w++) pop_check($sformatf("bp_rx%0d", w), 8'(8'h31 + w));
    wait_done();
    check("bp_edges_total", 32'(edges - e0), 32'd96);
    check("bp_ss_falls", 32'(ss_fall - f0), 32'd1);
    check("bp_ss_pattern", 32'(ss_bad - s0), 32'd0);
    check("bp_rx_empty", 32'(rx_valid), 32'd0);

    // Reset after 5 sclk edges
    cfg_ss_sel = 3'd0; exp_ss = 5'h1E;
    e0 = edges;
    push(8'hC3, 1'b1);
    n = 0;
    while ((edges - e0) < 5 && n < 200) begin @(negedge clk); #1; n++; end
    check("rst_mid_edges", 32'(edges - e0), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ss_n", 32'(ss_n), 32'h1F);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_mid_no_partial", 32'(rx_valid), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);

    // Out-of-range select: normal timing, no slave selected
    cfg_ss_sel = 3'd7;
    e0 = edges; l0 = low_cyc; b0 = busy_cyc;
    push(8'h5A, 1'b1);
    wait_done();
    check("sel7_ss_low", 32'(low_cyc - l0), 32'd0);
    check("sel7_busy_cycles", 32'(busy_cyc - b0), 32'd38);
    check("sel7_edges", 32'(edges - e0), 32'd16);
    pop_check("sel7_rx", 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
